stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Stopwatch timekeeping controller: owns the four BCD digits (MM:SS) that feed the seven-segment display block.
- Sequences the run, pause and adjust modes from the debounced button pulses and the adj/sel switch levels.
- Counts on single-cycle tick enables produced by the clock-divider block. Everything runs in the single system clock domain; no derived clocks.

Parameters:
MINUTE_MAX, 59, highest minute value before wrap to 00; BCD-decomposed internally; legal range 1..99.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
tick_1hz  input  1  single-cycle enable, one per second; drives normal counting.
tick_2hz  input  1  single-cycle enable, two per second; drives adjust-mode increments.
pse_pulse  input  1  debounced single-cycle pulse from the pause button.
adj  input  1  level; 1 = adjust mode.
sel  input  1  level, meaningful only in adjust mode; 0 = adjust minutes, 1 = adjust seconds.
sec_one  output  4  BCD seconds units, 0..9.
sec_ten  output  4  BCD seconds tens, 0..5.
min_one  output  4  BCD minutes units, 0..9.
min_ten  output  4  BCD minutes tens, 0..9, bounded by MINUTE_MAX.
paused  output  1  registered pause flag.
rollover  output  1  one-cycle pulse on the run-mode wrap from MINUTE_MAX:59 to 00:00.

Behaviour:
- Reset: on rst=1 at posedge clk, all digits = 0, paused = 0, rollover = 0. rst dominates every other input in that cycle.
- Registered outputs: all outputs are registered. A digit update appears on the edge at which the qualifying tick is sampled high (zero-cycle latency from tick to register).
- Mode, derived each cycle:
  - ADJUST when adj=1.
  - Otherwise PAUSED when paused=1.
  - Otherwise RUN.
- pause flag:
  - pse_pulse=1 toggles paused in every mode, including ADJUST.
  - A toggle made in ADJUST takes effect when adj returns to 0.
  - Leaving ADJUST returns to RUN or PAUSED according to the flag.
- RUN, on tick_1hz=1:
  - sec_one increments.
  - 9 -> 0 with carry into sec_ten.
  - sec_ten 5 with carry -> 0 with carry into minutes.
  - Minutes increment as a BCD pair.
  - At MINUTE_MAX with carry, minutes -> 00 and rollover=1 for exactly that one cycle.
  - tick_2hz is ignored.
- PAUSED: digits hold; tick_1hz and tick_2hz are ignored; rollover=0.
- ADJUST, on tick_2hz=1:
  - sel=1: seconds pair increments 00..59 and wraps to 00; no carry into minutes.
  - sel=0: minutes pair increments 00..MINUTE_MAX and wraps to 00; seconds untouched.
  - No rollover pulse in ADJUST. tick_1hz is ignored.
- sel change mid-adjust: takes effect at the next tick_2hz; no immediate effect.
- adj change: adj rising or falling between ticks loses no count state. The first tick after the change follows the new mode.
- Simultaneous events:
  - RUN with tick_1hz and pse_pulse in the same cycle: the increment is applied and paused becomes 1.
  - PAUSED with tick_1hz and pse_pulse in the same cycle: no increment; paused becomes 0.
  - tick_1hz and tick_2hz together: only the tick relevant to the current mode acts.
- Invariants:
  - Never outputs sec_one > 9, sec_ten > 5, min_one > 9, or minutes > MINUTE_MAX.
  - Illegal register contents are not expected, because rst initialises all state.
- Mid-operation reset: rst in any mode (including mid-adjust, with any tick asserted) yields 00:00, paused=0, rollover=0 on that edge.

Test Plan:
- rst, then 60 tick_1hz pulses -> 01:00; paused=0 and rollover never asserted.
- Adjust to 59:58 (MINUTE_MAX=59), adj=0, 2 tick_1hz pulses -> 59:59 then 00:00; rollover=1 for exactly the second-tick cycle, 0 otherwise.
- At 00:10, pse_pulse, then 5 tick_1hz pulses -> digits stay 00:10 and paused=1; pse_pulse plus 1 tick_1hz in one cycle -> still 00:10, paused=0; next tick_1hz -> 00:11.
- At 00:58, adj=1, sel=1, 3 tick_2hz pulses interleaved with tick_1hz -> 00:01, minutes unchanged, tick_1hz has no effect.
- At 59:30, adj=1, sel=0, 1 tick_2hz -> 00:30, rollover stays 0; switch sel=1 between ticks, next tick_2hz -> 00:31.
- At 12:34 in RUN, assert rst together with tick_1hz and pse_pulse -> 00:00, paused=0, rollover=0 on that edge.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Control inputs and BCD display outputs of the stopwatch timekeeping controller.
// The master side produces the tick/button/switch signals; the slave is the controller.
interface stopwatch_ctrl_if;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       pse_pulse;
  logic       adj;
  logic       sel;
  logic [3:0] sec_one;
  logic [3:0] sec_ten;
  logic [3:0] min_one;
  logic [3:0] min_ten;
  logic       paused;
  logic       rollover;

  modport master (
    output tick_1hz, tick_2hz, pse_pulse, adj, sel,
    input  sec_one, sec_ten, min_one, min_ten, paused, rollover
  );

  modport slave (
    input  tick_1hz, tick_2hz, pse_pulse, adj, sel,
    output sec_one, sec_ten, min_one, min_ten, paused, rollover
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch timekeeping controller: MM:SS BCD counters with run, pause and adjust modes.
// All outputs are registered; ticks act on the edge at which they are sampled.
module stopwatch_ctrl #(
  parameter int unsigned MINUTE_MAX = 59
) (
  input logic              clk,
  input logic              rst,
  stopwatch_ctrl_if.slave  bus
);

  localparam logic [3:0] MinTenMax = 4'(MINUTE_MAX / 10);
  localparam logic [3:0] MinOneMax = 4'(MINUTE_MAX % 10);

  typedef enum logic [1:0] {ModeRun, ModePaused, ModeAdjust} mode_e;

  logic [3:0] sec_one_q, sec_one_d, sec_ten_q, sec_ten_d;
  logic [3:0] min_one_q, min_one_d, min_ten_q, min_ten_d;
  logic       paused_q, paused_d, rollover_q, rollover_d;

  logic [3:0] sec_one_inc, sec_ten_inc, min_one_inc, min_ten_inc;
  logic       sec_at_max, min_at_max;
  mode_e      mode;

  assign sec_at_max = (sec_ten_q == 4'd5) && (sec_one_q == 4'd9);
  assign min_at_max = (min_ten_q == MinTenMax) && (min_one_q == MinOneMax);

  // Mode is re-derived every cycle, so leaving adjust lands on whatever the flag says.
  assign mode = bus.adj ? ModeAdjust : (paused_q ? ModePaused : ModeRun);

  // Wrapping increments of each BCD pair; used by both run and adjust modes.
  always_comb begin
    sec_one_inc = sec_one_q + 4'd1;
    sec_ten_inc = sec_ten_q;
    if (sec_one_q == 4'd9) begin
      sec_one_inc = 4'd0;
      sec_ten_inc = (sec_ten_q == 4'd5) ? 4'd0 : sec_ten_q + 4'd1;
    end
    min_one_inc = min_one_q + 4'd1;
    min_ten_inc = min_ten_q;
    if (min_at_max) begin
      min_one_inc = 4'd0;
      min_ten_inc = 4'd0;
    end else if (min_one_q == 4'd9) begin
      min_one_inc = 4'd0;
      min_ten_inc = min_ten_q + 4'd1;
    end
  end

  always_comb begin
    sec_one_d  = sec_one_q;
    sec_ten_d  = sec_ten_q;
    min_one_d  = min_one_q;
    min_ten_d  = min_ten_q;
    rollover_d = 1'b0;
    paused_d   = paused_q ^ bus.pse_pulse;
    unique case (mode)
      ModeRun: begin
        if (bus.tick_1hz) begin
          sec_one_d = sec_one_inc;
          sec_ten_d = sec_ten_inc;
          if (sec_at_max) begin
            min_one_d  = min_one_inc;
            min_ten_d  = min_ten_inc;
            rollover_d = min_at_max;
          end
        end
      end
      ModeAdjust: begin
        if (bus.tick_2hz) begin
          if (bus.sel) begin
            sec_one_d = sec_one_inc;
            sec_ten_d = sec_ten_inc;
          end else begin
            min_one_d = min_one_inc;
            min_ten_d = min_ten_inc;
          end
        end
      end
      ModePaused: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_one_q  <= 4'd0;
      sec_ten_q  <= 4'd0;
      min_one_q  <= 4'd0;
      min_ten_q  <= 4'd0;
      paused_q   <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      sec_one_q  <= sec_one_d;
      sec_ten_q  <= sec_ten_d;
      min_one_q  <= min_one_d;
      min_ten_q  <= min_ten_d;
      paused_q   <= paused_d;
      rollover_q <= rollover_d;
    end
  end

  assign bus.sec_one  = sec_one_q;
  assign bus.sec_ten  = sec_ten_q;
  assign bus.min_one  = min_one_q;
  assign bus.min_ten  = min_ten_q;
  assign bus.paused   = paused_q;
  assign bus.rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: an integer-time model queues expected state per
// driven cycle; entries are popped and compared one cycle later, after the clock edge.
module tb_stopwatch_ctrl;

  localparam int unsigned MinuteMax = 59;

  typedef struct packed {
    logic [15:0] digits;
    logic        paused;
    logic        rollover;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(.MINUTE_MAX(MinuteMax)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  int   m_sec = 0;
  int   m_min = 0;
  bit   m_paused = 1'b0;
  bit   m_roll = 1'b0;

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int mins, input int secs);
    logic [15:0] v;
    v = {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
    return v;
  endfunction

  function automatic logic [15:0] dut_digits();
    return {bus.min_ten, bus.min_one, bus.sec_ten, bus.sec_one};
  endfunction

  // Reference behaviour, written in plain integers rather than BCD digits.
  task automatic model(input bit t1, input bit t2, input bit p, input bit a, input bit s,
                       input bit r);
    exp_t e;
    if (r) begin
      m_sec = 0; m_min = 0; m_paused = 0; m_roll = 0;
    end else begin
      m_roll = 0;
      if (a) begin
        if (t2) begin
          if (s) m_sec = (m_sec + 1) % 60;
          else   m_min = (m_min + 1) % (MinuteMax + 1);
        end
      end else if (!m_paused && t1) begin
        m_sec++;
        if (m_sec == 60) begin
          m_sec = 0;
          m_min++;
          if (m_min > MinuteMax) begin
            m_min  = 0;
            m_roll = 1;
          end
        end
      end
      m_paused = m_paused ^ p;
    end
    e.digits   = to_bcd(m_min, m_sec);
    e.paused   = m_paused;
    e.rollover = m_roll;
    sb_q.push_back(e);
  endtask

  task automatic step(input bit t1, input bit t2, input bit p, input bit a, input bit s,
                      input bit r);
    exp_t e;
    bus.tick_1hz  = t1;
    bus.tick_2hz  = t2;
    bus.pse_pulse = p;
    bus.adj       = a;
    bus.sel       = s;
    rst           = r;
    model(t1, t2, p, a, s, r);
    @(posedge clk);
    #1;
    bus.tick_1hz  = 1'b0;
    bus.tick_2hz  = 1'b0;
    bus.pse_pulse = 1'b0;
    rst           = 1'b0;
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check_val("digits", 32'(dut_digits()), 32'(e.digits));
      check_val("paused", 32'(bus.paused), 32'(e.paused));
      check_val("rollover", 32'(bus.rollover), 32'(e.rollover));
    end
  endtask

  // One qualifying tick followed by a quiet cycle, in run or adjust mode.
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic adj_ticks(input int n, input bit s);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, 1, s, 0);
      step(0, 0, 0, 1, s, 0);
    end
  endtask

  task automatic expect_time(input string tag, input logic [15:0] v);
    check_val(tag, 32'(dut_digits()), 32'(v));
  endtask

  initial begin
    bus.tick_1hz = 0; bus.tick_2hz = 0; bus.pse_pulse = 0; bus.adj = 0; bus.sel = 0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 1);
    expect_time("reset_time", 16'h0000);

    run_ticks(60);
    expect_time("count_to_0100", 16'h0100);

    // Set 59:58 in adjust, then let run mode wrap.
    adj_ticks(58, 0);
    adj_ticks(58, 1);
    expect_time("adjust_5958", 16'h5958);
    step(0, 0, 0, 0, 0, 0);
    run_ticks(1);
    expect_time("run_5959", 16'h5959);
    step(1, 0, 0, 0, 0, 0);
    check_val("rollover_pulse", 32'(bus.rollover), 1);
    expect_time("wrap_0000", 16'h0000);
    step(0, 0, 0, 0, 0, 0);

    // Pause behaviour, including simultaneous tick and pause pulse.
    run_ticks(10);
    step(0, 0, 1, 0, 0, 0);
    run_ticks(5);
    expect_time("paused_hold", 16'h0010);
    step(1, 0, 1, 0, 0, 0);
    expect_time("unpause_no_inc", 16'h0010);
    run_ticks(1);
    expect_time("resume_0011", 16'h0011);
    step(1, 0, 1, 0, 0, 0);
    expect_time("pause_with_inc", 16'h0012);
    step(0, 0, 1, 0, 0, 0);

    // Seconds adjust wrap with tick_1hz interleaved.
    run_ticks(46);
    expect_time("run_0058", 16'h0058);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1, 1, 0);
      step(1, 0, 0, 1, 1, 0);
    end
    expect_time("adj_sec_wrap", 16'h0001);

    // Minutes adjust wrap, sel change between ticks, both ticks together.
    adj_ticks(59, 0);
    adj_ticks(29, 1);
    expect_time("adjust_5930", 16'h5930);
    step(0, 1, 0, 1, 0, 0);
    expect_time("adj_min_wrap", 16'h0030);
    step(0, 0, 0, 1, 1, 0);
    expect_time("sel_no_immediate", 16'h0030);
    step(1, 1, 0, 1, 1, 0);
    expect_time("adj_sel_sec", 16'h0031);

    // Pause toggled in adjust applies once adj drops.
    step(0, 0, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    expect_time("adj_pause_hold", 16'h0031);
    step(0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    expect_time("run_ignores_2hz", 16'h0032);

    // Reach 12:34 in run, then reset with tick and pause pulse asserted.
    adj_ticks(12, 0);
    adj_ticks(1, 1);
    run_ticks(1);
    expect_time("run_1234", 16'h1234);
    step(1, 0, 1, 0, 0, 1);
    expect_time("reset_mid_run", 16'h0000);
    adj_ticks(3, 1);
    step(1, 1, 1, 1, 0, 1);
    expect_time("reset_mid_adj", 16'h0000);
    check_val("paused_after_rst", 32'(bus.paused), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
